// File: rtl/hangman_kb_pkg.sv
// Shared constants for the hangman keyboard decoder: scan codes, the
// prefix-tracking FSM encoding and the letter index width.
package hangman_kb_pkg;

    localparam int LETTER_W = 5;

    // PS/2 set-2 prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    // Command keys: Enter is a normal code, the others follow an E0 prefix
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_INSERT = 8'h70;
    localparam logic [7:0] SC_END    = 8'h69;
    localparam logic [7:0] SC_DELETE = 8'h71;

    // Prefix FSM: which prefix bytes have been seen for the key in flight
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

endpackage

// File: rtl/scan_to_letter.sv
// Maps a normal (non-extended) scan code to a letter index A=0 .. Z=25.
// is_letter is low for every code that is not one of the 26 letter keys.
module scan_to_letter
    import hangman_kb_pkg::*;
(
    input  logic [7:0]          code,
    output logic [LETTER_W-1:0] index,
    output logic                is_letter
);

    // Pure lookup; unmapped codes report index 0 with is_letter low
    always_comb begin
        index     = '0;
        is_letter = 1'b1;
        case (code)
            8'h1C: index = 5'd0;
            8'h32: index = 5'd1;
            8'h21: index = 5'd2;
            8'h23: index = 5'd3;
            8'h24: index = 5'd4;
            8'h2B: index = 5'd5;
            8'h34: index = 5'd6;
            8'h33: index = 5'd7;
            8'h43: index = 5'd8;
            8'h3B: index = 5'd9;
            8'h42: index = 5'd10;
            8'h4B: index = 5'd11;
            8'h3A: index = 5'd12;
            8'h31: index = 5'd13;
            8'h44: index = 5'd14;
            8'h4D: index = 5'd15;
            8'h15: index = 5'd16;
            8'h2D: index = 5'd17;
            8'h1B: index = 5'd18;
            8'h2C: index = 5'd19;
            8'h3C: index = 5'd20;
            8'h2A: index = 5'd21;
            8'h1D: index = 5'd22;
            8'h22: index = 5'd23;
            8'h35: index = 5'd24;
            8'h1A: index = 5'd25;
            default: is_letter = 1'b0;
        endcase
    end

endmodule

// File: rtl/hangman_key_decoder.sv
// Turns the PS/2 byte stream into hangman game commands: a held letter
// level with its index, and one-cycle start/endinput/try/wipe strobes.
// Prefix bytes (E0, F0) are tracked by a small FSM that gives up after
// PREFIX_TIMEOUT idle cycles; typematic repeats are suppressed by per-key
// held flags.
//
// Input handshake: ps2_valid is a one-cycle strobe with no back-pressure.
// ps2_byte is sampled on every clk edge where ps2_valid is high, including
// back-to-back cycles, and every such byte is consumed.
module hangman_key_decoder
    import hangman_kb_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 50000000,
    parameter int TO_W           = 26
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          ps2_byte,
    input  logic                ps2_valid,
    output logic                load,
    output logic [LETTER_W-1:0] letter,
    output logic                start,
    output logic                endinput,
    output logic                try,
    output logic                wipe
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [TO_W-1:0]     to_cnt;
    logic                timeout_hit;

    // Decoded key event for the current byte
    logic                ev_make;
    logic                ev_brk;
    logic                ev_ext;

    logic [LETTER_W-1:0] scan_index;
    logic                scan_is_letter;

    logic                held_enter;
    logic                held_insert;
    logic                held_end;
    logic                held_delete;

    scan_to_letter u_scan_to_letter (
        .code      (ps2_byte),
        .index     (scan_index),
        .is_letter (scan_is_letter)
    );

    assign timeout_hit = (state != S_IDLE) && (to_cnt == TO_LAST);

    // Next-state and event decode; a byte always wins over a timeout
    always_comb begin
        next_state = state;
        ev_make    = 1'b0;
        ev_brk     = 1'b0;
        ev_ext     = 1'b0;
        if (ps2_valid) begin
            case (state)
                S_IDLE: begin
                    if (ps2_byte == SC_E0) begin
                        next_state = S_EXT;
                    end else if (ps2_byte == SC_F0) begin
                        next_state = S_BRK;
                    end else begin
                        ev_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (ps2_byte == SC_F0) begin
                        next_state = S_EXT_BRK;
                    end else begin
                        ev_make    = 1'b1;
                        ev_ext     = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_BRK: begin
                    ev_brk     = 1'b1;
                    next_state = S_IDLE;
                end
                default: begin
                    ev_brk     = 1'b1;
                    ev_ext     = 1'b1;
                    next_state = S_IDLE;
                end
            endcase
        end else if (timeout_hit) begin
            next_state = S_IDLE;
        end
    end

    // Prefix FSM state and its idle-wait counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            to_cnt <= '0;
        end else begin
            state <= next_state;
            if (ps2_valid || state == S_IDLE || timeout_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Letter level: a make loads the index, only a break of that letter drops it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load   <= 1'b0;
            letter <= '0;
        end else if (scan_is_letter && !ev_ext) begin
            if (ev_make) begin
                load   <= 1'b1;
                letter <= scan_index;
            end else if (ev_brk && scan_index == letter) begin
                load <= 1'b0;
            end
        end
    end

    // Command keys: pulse on the first make, ignore repeats until the break
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start       <= 1'b0;
            endinput    <= 1'b0;
            try         <= 1'b0;
            wipe        <= 1'b0;
            held_enter  <= 1'b0;
            held_insert <= 1'b0;
            held_end    <= 1'b0;
            held_delete <= 1'b0;
        end else begin
            start    <= 1'b0;
            endinput <= 1'b0;
            try      <= 1'b0;
            wipe     <= 1'b0;
            if (ev_make && !ev_ext) begin
                if (ps2_byte == SC_ENTER && !held_enter) begin
                    try        <= 1'b1;
                    held_enter <= 1'b1;
                end
            end else if (ev_make && ev_ext) begin
                if (ps2_byte == SC_INSERT && !held_insert) begin
                    start       <= 1'b1;
                    held_insert <= 1'b1;
                end
                if (ps2_byte == SC_END && !held_end) begin
                    endinput <= 1'b1;
                    held_end <= 1'b1;
                end
                if (ps2_byte == SC_DELETE && !held_delete) begin
                    wipe        <= 1'b1;
                    held_delete <= 1'b1;
                end
            end else if (ev_brk && !ev_ext) begin
                if (ps2_byte == SC_ENTER) begin
                    held_enter <= 1'b0;
                end
            end else if (ev_brk && ev_ext) begin
                if (ps2_byte == SC_INSERT) begin
                    held_insert <= 1'b0;
                end
                if (ps2_byte == SC_END) begin
                    held_end <= 1'b0;
                end
                if (ps2_byte == SC_DELETE) begin
                    held_delete <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hangman_key_decoder.sv
// Bench for hangman_key_decoder: directed key sequences followed by random
// byte traffic, every cycle compared against a key-level reference model.
module tb_hangman_key_decoder;

    localparam int TO = 16;

    logic       clk;
    logic       resetn;
    logic [7:0] ps2_byte;
    logic       ps2_valid;
    logic       load;
    logic [4:0] letter;
    logic       start;
    logic       endinput;
    logic       try;
    logic       wipe;

    int n_cmp = 0;
    int n_err = 0;
    int try_seen = 0;
    int start_seen = 0;

    hangman_key_decoder #(
        .PREFIX_TIMEOUT (TO),
        .TO_W           (5)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_byte  (ps2_byte),
        .ps2_valid (ps2_valid),
        .load      (load),
        .letter    (letter),
        .start     (start),
        .endinput  (endinput),
        .try       (try),
        .wipe      (wipe)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] letter_codes [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    logic       m_load;
    logic [4:0] m_letter;
    logic       m_start, m_end, m_try, m_wipe;
    bit         m_ext_pending, m_brk_pending;
    int         m_idle;
    bit         held [logic [8:0]];

    function automatic int letter_index(input logic [7:0] b);
        for (int i = 0; i < 26; i++) begin
            if (letter_codes[i] == b) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_load = 0; m_letter = 0;
        m_start = 0; m_end = 0; m_try = 0; m_wipe = 0;
        m_ext_pending = 0; m_brk_pending = 0; m_idle = 0;
        held.delete();
    endtask

    // Apply one clock edge: a key action completes when a non-prefix byte arrives
    task automatic model_apply(input bit v, input logic [7:0] b);
        logic [8:0] key;
        int idx;
        bit special;
        m_start = 0; m_end = 0; m_try = 0; m_wipe = 0;
        if (!v) begin
            if (m_ext_pending || m_brk_pending) begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_ext_pending = 0;
                    m_brk_pending = 0;
                end
            end
            return;
        end
        m_idle = 0;
        if (!m_brk_pending && b == 8'hF0) begin
            m_brk_pending = 1;
            return;
        end
        if (!m_ext_pending && !m_brk_pending && b == 8'hE0) begin
            m_ext_pending = 1;
            return;
        end
        key = {m_ext_pending, b};
        idx = m_ext_pending ? -1 : letter_index(b);
        special = (key == 9'h05A) || (key == 9'h170) || (key == 9'h169) || (key == 9'h171);
        if (!m_brk_pending) begin
            if (idx >= 0) begin
                m_letter = 5'(idx);
                m_load = 1;
            end
            if (special && !(held.exists(key) && held[key])) begin
                held[key] = 1;
                if (key == 9'h05A) m_try = 1;
                if (key == 9'h170) m_start = 1;
                if (key == 9'h169) m_end = 1;
                if (key == 9'h171) m_wipe = 1;
            end
        end else begin
            if (idx >= 0 && idx == int'(m_letter)) m_load = 0;
            if (special) held[key] = 0;
        end
        m_ext_pending = 0;
        m_brk_pending = 0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("load", {7'd0, load}, {7'd0, m_load});
        check("letter", {3'd0, letter}, {3'd0, m_letter});
        check("start", {7'd0, start}, {7'd0, m_start});
        check("endinput", {7'd0, endinput}, {7'd0, m_end});
        check("try", {7'd0, try}, {7'd0, m_try});
        check("wipe", {7'd0, wipe}, {7'd0, m_wipe});
    endtask

    // ---------------- drivers ----------------
    task automatic step(input bit v, input logic [7:0] b);
        @(negedge clk);
        ps2_valid = v;
        ps2_byte  = b;
        @(posedge clk);
        model_apply(v, b);
        #1;
        ps2_valid = 1'b0;
        if (try === 1'b1) try_seen++;
        if (start === 1'b1) start_seen++;
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] specials [4];
        specials = '{8'h5A, 8'h69, 8'h70, 8'h71};
        resetn    = 1'b0;
        ps2_valid = 1'b0;
        ps2_byte  = 8'h00;
        model_reset();
        reset_dut();

        // A press and release
        send(8'h1C); send(8'hF0); send(8'h1C);
        idle(1);

        // Typematic T, then Z overwrites; only Z's break drops load
        send(8'h2C); send(8'h2C); send(8'h2C);
        send(8'h1A);
        send(8'hF0); send(8'h2C);
        send(8'hF0); send(8'h1A);
        idle(1);

        // Enter repeat suppression: exactly two try pulses
        try_seen = 0;
        send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A); send(8'h5A);
        idle(2);
        check("try_count", 8'(try_seen), 8'd2);
        send(8'hF0); send(8'h5A);

        // Extended keys, each released; 69 without prefix is ignored
        send(8'hE0); send(8'h69); send(8'hE0); send(8'hF0); send(8'h69);
        send(8'hE0); send(8'h70); send(8'hE0); send(8'hF0); send(8'h70);
        send(8'hE0); send(8'h71); send(8'hE0); send(8'hF0); send(8'h71);
        send(8'h69);
        idle(1);

        // Prefix timeout: long wait drops E0 so 5A is a plain Enter
        send(8'hE0); idle(TO + 4); send(8'h5A);
        send(8'hF0); send(8'h5A);

        // Timeout boundary: one cycle short keeps the prefix, exact limit drops it
        start_seen = 0;
        send(8'hE0); idle(TO - 1); send(8'h70);
        send(8'hE0); send(8'hF0); send(8'h70);
        send(8'hE0); idle(TO); send(8'h70);
        idle(1);
        check("start_count", 8'(start_seen), 8'd1);

        // Reset between a prefix and its key byte
        send(8'h24);
        send(8'hE0); send(8'hF0);
        reset_dut();
        send(8'h1C);
        idle(1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int sel;
            logic [7:0] b;
            sel = $urandom_range(0, 9);
            if (sel <= 3)      b = letter_codes[$urandom_range(0, 5)];
            else if (sel == 4) b = 8'hF0;
            else if (sel == 5) b = 8'hE0;
            else if (sel <= 7) b = specials[$urandom_range(0, 3)];
            else               b = 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, b);
            if ($urandom_range(0, 59) == 0) idle($urandom_range(TO - 2, TO + 2));
            if ($urandom_range(0, 199) == 0) reset_dut();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
